instr_fetch: RTL and testbench

Multi-cycle instruction fetch unit sitting directly downstream of the `pc` register. It issues one instruction-memory read per program-counter value and buffers the returned word until the decode stage accepts it. It then pulses `pc_en` so the `pc` register loads `next_pc`. Redirects from branch/jump resolution flush any in-flight fetch; a misaligned PC produces a fetch fault instead of a memory access.

---
 rtl/rv32_pkg.sv | 6 +
 rtl/instr_fetch.sv | 66 ++++++
 tb/tb_instr_fetch.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/rv32_pkg.sv
// rv32_pkg: shared fetch-state encoding and reset/NOP constants for the RV32 front end
package rv32_pkg;
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DROP, S_HOLD} fetch_state_t;
  localparam logic [31:0] DEFAULT_NOP = 32'h0000_0013;
  localparam logic [31:0] RESET_PC    = 32'h0000_0000;
endpackage

// File: rtl/instr_fetch.sv
// instr_fetch: one-request-at-a-time instruction fetch with redirect flush and misalignment fault
module instr_fetch
  import rv32_pkg::*;
#(
  parameter logic        CHECK_ALIGN = 1'b1,
  parameter logic [31:0] NOP_INSTR   = DEFAULT_NOP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic        pc_en,
  input  logic        redirect,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_fault
);
  fetch_state_t r_state, w_next;
  logic [31:0]  r_instr, r_instr_pc;
  logic         r_fault;
  logic         w_mis, w_accept;
  assign w_mis         = CHECK_ALIGN && (pc[1:0] != 2'b00);
  assign imem_req_addr = CHECK_ALIGN ? pc : {pc[31:2], 2'b00};
  assign w_accept      = imem_req_valid && imem_req_ready;
  assign instr_valid   = r_state == S_HOLD;
  assign instr         = (instr_valid && !r_fault) ? r_instr : NOP_INSTR;
  assign instr_pc      = r_instr_pc;
  assign instr_fault   = r_fault;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= S_IDLE;
    else r_state <= w_next;
  // next state, request strobe and pc load pulse; a redirect always wins over the normal path
  always_comb begin
    w_next         = r_state;
    imem_req_valid = (r_state == S_REQ) && !w_mis;
    pc_en          = (r_state == S_HOLD && instr_ready && !redirect) || (redirect && r_state != S_IDLE);
    case (r_state)
      S_IDLE: w_next = S_REQ;
      S_REQ:  w_next = redirect ? (w_accept ? S_DROP : S_REQ) : w_mis ? S_HOLD : w_accept ? S_WAIT : S_REQ;
      S_WAIT: w_next = redirect ? (imem_rsp_valid ? S_REQ : S_DROP) : imem_rsp_valid ? S_HOLD : S_WAIT;
      S_DROP: w_next = imem_rsp_valid ? S_REQ : S_DROP;
      S_HOLD: w_next = (instr_ready || redirect) ? S_REQ : S_HOLD;
      default: w_next = S_IDLE;
    endcase
  end
  // buffer: pc and fault latched when the request resolves, data latched on the response
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_instr    <= NOP_INSTR;
      r_instr_pc <= 32'd0;
      r_fault    <= 1'b0;
    end else begin
      if (r_state == S_REQ && !redirect && (w_mis || w_accept)) begin
        r_instr_pc <= pc;
        r_fault    <= w_mis;
      end
      if (r_state == S_WAIT && !redirect && imem_rsp_valid) r_instr <= imem_rsp_data;
    end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: pc register + memory model around instr_fetch, scoreboard on consumed instructions
module tb_instr_fetch;
  import rv32_pkg::*;
  typedef struct {logic [31:0] pc; logic [31:0] ins; logic flt;} exp_t;
  logic clk = 0, rst = 0;
  logic [31:0] pc, tgt = 0;
  logic redirect = 0, imem_req_ready = 1, instr_ready = 1;
  logic pc_en, imem_req_valid, imem_rsp_valid, instr_valid, instr_fault;
  logic [31:0] imem_req_addr, imem_rsp_data, instr, instr_pc;
  logic pend = 0;
  logic [31:0] paddr = 0;
  int lat = 0, cnt = 0, n_req = 0, n_chk = 0, n_err = 0, n0, cyc;
  exp_t sb[$];
  exp_t tbl[6];

  instr_fetch dut (
    .clk(clk), .rst(rst), .pc(pc), .pc_en(pc_en), .redirect(redirect),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .instr_pc(instr_pc), .instr_fault(instr_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h1234_5678;
    if (a == 32'h0000_2000) return 32'hDEAD_BEEF;
    return 32'h0000_0093 ^ (a * 32'h0001_0001);
  endfunction

  always @(posedge clk or posedge rst)
    if (rst) pc <= RESET_PC;
    else if (pc_en) pc <= redirect ? tgt : pc + 32'd4;

  assign imem_rsp_valid = pend && cnt == 0;
  assign imem_rsp_data  = imem_rsp_valid ? mem_word(paddr) : 32'hBAD0_BAD0;
  always @(posedge clk) begin
    if (imem_req_valid && imem_req_ready) begin
      pend <= 1'b1; paddr <= imem_req_addr; cnt <= lat; n_req <= n_req + 1;
    end else if (imem_rsp_valid) pend <= 1'b0;
    else if (pend && cnt != 0) cnt <= cnt - 1;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin n_err++; $display("FAIL %s: got %h expected %h", nm, got, exp); end
  endtask
  task automatic chkb(input string nm, input logic got, input logic exp);
    n_chk++;
    if (got !== exp) begin n_err++; $display("FAIL %s: got %b expected %b", nm, got, exp); end
  endtask
  task automatic chki(input string nm, input int got, input int exp);
    n_chk++;
    if (got != exp) begin n_err++; $display("FAIL %s: got %0d expected %0d", nm, got, exp); end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (instr_valid && instr_ready && !redirect) begin
      if (sb.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL sb_unexpected: got pc %h instr %h with no expected entry", instr_pc, instr);
      end else begin
        e = sb.pop_front();
        chk("sb_pc", instr_pc, e.pc);
        chk("sb_instr", instr, e.ins);
        chkb("sb_fault", instr_fault, e.flt);
      end
    end
  end

  task automatic step; @(posedge clk); #1; endtask
  task automatic wait_valid(input int max);
    int k = 0;
    while (!instr_valid && k < max) begin step(); k++; end
    chkb("wait_valid", instr_valid, 1'b1);
  endtask
  task automatic do_redirect(input logic [31:0] t);
    redirect = 1; tgt = t;
    #1 chkb("redir_pc_en", pc_en, 1'b1);
    step(); redirect = 0;
  endtask
  task automatic consume;
    instr_ready = 1;
    #1 chkb("consume_pc_en", pc_en, 1'b1);
    step(); instr_ready = 0;
  endtask
  task automatic chk_reset;
    chkb("rst_pc_en", pc_en, 1'b0);
    chkb("rst_req_valid", imem_req_valid, 1'b0);
    chk("rst_req_addr", imem_req_addr, pc);
    chkb("rst_instr_valid", instr_valid, 1'b0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chkb("rst_fault", instr_fault, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{32'h0000_0020, mem_word(32'h0000_0020), 1'b0};
    tbl[1] = '{32'h7FFF_FFFC, mem_word(32'h7FFF_FFFC), 1'b0};
    tbl[2] = '{32'h0000_0103, 32'h0000_0013, 1'b1};
    tbl[3] = '{32'h0000_0202, 32'h0000_0013, 1'b1};
    tbl[4] = '{32'hFFFF_FFF0, mem_word(32'hFFFF_FFF0), 1'b0};
    tbl[5] = '{32'h0000_0041, 32'h0000_0013, 1'b1};
    rst = 1;
    sb.push_back('{32'h0, 32'h0000_0093, 1'b0});
    sb.push_back('{32'h4, mem_word(32'h4), 1'b0});
    sb.push_back('{32'h8, mem_word(32'h8), 1'b0});
    step(); step();
    chk_reset();
    rst = 0;
    step();
    chkb("first_req_valid", imem_req_valid, 1'b1);
    chk("first_req_addr", imem_req_addr, 32'h0);
    step();
    chkb("wait_req_valid", imem_req_valid, 1'b0);
    chkb("wait_instr_valid", instr_valid, 1'b0);
    step();
    chkb("first_valid", instr_valid, 1'b1);
    chk("first_instr", instr, 32'h0000_0093);
    chk("first_pc", instr_pc, 32'h0);
    chkb("first_pc_en", pc_en, 1'b1);
    for (int k = 0; k < 2; k++) begin
      cyc = 0;
      do begin step(); cyc++; end while (!instr_valid && cyc < 10);
      chki("throughput", cyc, 3);
    end
    step(); instr_ready = 0;
    wait_valid(10);
    sb.push_back('{32'h100, 32'h1234_5678, 1'b0});
    do_redirect(32'h100);
    wait_valid(10);
    for (int k = 0; k < 5; k++) begin
      chk("hold_instr", instr, 32'h1234_5678);
      chk("hold_pc", instr_pc, 32'h100);
      chkb("hold_valid", instr_valid, 1'b1);
      chkb("hold_pc_en", pc_en, 1'b0);
      step();
    end
    consume();
    wait_valid(10);
    n0 = n_req;
    sb.push_back('{32'hA, 32'h0000_0013, 1'b1});
    do_redirect(32'hA);
    chkb("fault_req_valid", imem_req_valid, 1'b0);
    step();
    chkb("fault_valid", instr_valid, 1'b1);
    chkb("fault_flag", instr_fault, 1'b1);
    chk("fault_pc", instr_pc, 32'hA);
    chk("fault_instr", instr, 32'h0000_0013);
    consume();
    chki("fault_no_req", n_req, n0);
    for (int i = 0; i < 6; i++) begin
      wait_valid(20);
      sb.push_back(tbl[i]);
      do_redirect(tbl[i].pc);
      wait_valid(20);
      chk("tbl_pc", instr_pc, tbl[i].pc);
      chk("tbl_instr", instr, tbl[i].ins);
      chkb("tbl_fault", instr_fault, tbl[i].flt);
      consume();
    end
    wait_valid(20);
    lat = 3; n0 = n_req;
    do_redirect(32'h2000);
    step();
    redirect = 1; tgt = 32'h1000_0000;
    #1 chkb("wait_redir_pc_en", pc_en, 1'b1);
    step(); redirect = 0;
    sb.push_back('{32'h1000_0000, mem_word(32'h1000_0000), 1'b0});
    wait_valid(20);
    chki("wait_redir_reqs", n_req, n0 + 2);
    lat = 0;
    consume();
    wait_valid(20);
    lat = 2; n0 = n_req;
    do_redirect(32'h3000);
    redirect = 1; tgt = 32'h4000;
    #1 chkb("same_pc_en", pc_en, 1'b1);
    chkb("same_req_valid", imem_req_valid, 1'b1);
    step(); redirect = 0;
    sb.push_back('{32'h4000, mem_word(32'h4000), 1'b0});
    wait_valid(20);
    chki("same_reqs", n_req, n0 + 2);
    lat = 0;
    consume();
    wait_valid(20);
    lat = 3;
    do_redirect(32'h5000);
    step();
    imem_req_ready = 0; rst = 1;
    #1 chk_reset();
    step(); rst = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      chkb("late_rsp_valid", instr_valid, 1'b0);
    end
    lat = 0; imem_req_ready = 1;
    sb.push_back('{32'h0, 32'h0000_0093, 1'b0});
    wait_valid(10);
    consume();
    for (int k = 0; k < 5; k++) step();
    chki("sb_left", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
